// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider.
// One quotient bit is produced per clock by shift-and-subtract; a start/busy/done
// handshake frames each operation. Divide-by-zero completes immediately with a flag.
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    // Captured divisor and the working accumulators of the iteration.
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] q_acc;
    logic [CNT_W-1:0] counter;

    // Result of the current iteration step, computed combinationally.
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] q_step;

    logic             ready;
    logic             accept;
    logic             last_step;
    logic             zero_divisor;

    // One restoring step: shift the next dividend bit into the partial remainder,
    // trial-subtract the divisor in WIDTH+1 bits, keep the difference when it is
    // non-negative. The partial remainder is always below the divisor, so after a
    // step its MSB is zero and only WIDTH bits need to be stored between steps.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] trial;
        shifted = {rem, q[WIDTH-1]};
        trial   = shifted - {1'b0, d};
        if (!trial[WIDTH]) begin
            div_step = {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {shifted[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Handshake qualifiers and the iteration datapath.
    always_comb begin
        ready              = (state == S_IDLE) || (state == S_DONE);
        accept             = start && ready;
        zero_divisor       = (divisor == '0);
        last_step          = (state == S_RUN) && (counter == CNT_W'(1));
        {rem_step, q_step} = div_step(rem_acc, q_acc, divisor_reg);
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = zero_divisor ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (counter == CNT_W'(1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = zero_divisor ? S_DONE : S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Step counter and architecturally visible results; results only move when
    // an operation completes, so they stay stable while the next one runs.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (zero_divisor) begin
                counter     <= '0;
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                counter     <= CNT_W'(WIDTH);
                div_by_zero <= 1'b0;
            end
        end else if (state == S_RUN) begin
            counter <= counter - CNT_W'(1);
            if (last_step) begin
                quotient  <= q_step;
                remainder <= rem_step;
            end
        end
    end

    // Working registers: loaded on an accepted start, advanced once per RUN cycle.
    // Their contents are meaningless outside RUN, so they carry no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            divisor_reg <= divisor;
            rem_acc     <= '0;
            q_acc       <= dividend;
        end else if (state == S_RUN) begin
            rem_acc <= rem_step;
            q_acc   <= q_step;
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider (WIDTH = 4).
module tb_seq_restoring_divider;

    localparam int WIDTH = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    // Called at a falling edge; presents a start for one rising edge and
    // returns at the falling edge right after that edge.
    task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Advances falling edges until done is seen or the budget runs out.
    task automatic wait_done(input int limit, output int cyc);
        int c = 0;
        while (done !== 1'b1 && c < limit) begin
            @(negedge clock);
            c++;
        end
        cyc = c;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (quotient !== 4'd0) begin n_fail++; $display("FAIL reset_quotient got %0d want 0", quotient); end
        n_checks++; if (remainder !== 4'd0) begin n_fail++; $display("FAIL reset_remainder got %0d want 0", remainder); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        drive_start(4'd13, 4'd4);
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy[%0d] got %b want 1", j, busy); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_early_done[%0d] got %b want 0", j, done); end
            n_checks++; if (quotient !== 4'd0) begin n_fail++; $display("FAIL basic_q_stable[%0d] got %0d want 0", j, quotient); end
            @(negedge clock);
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
        n_checks++; if (quotient !== 4'd3) begin n_fail++; $display("FAIL basic_quotient got %0d want 3", quotient); end
        n_checks++; if (remainder !== 4'd1) begin n_fail++; $display("FAIL basic_remainder got %0d want 1", remainder); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
        @(negedge clock);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
        n_checks++; if (quotient !== 4'd3) begin n_fail++; $display("FAIL basic_q_hold got %0d want 3", quotient); end
    endtask

    task automatic test_values();
        int cyc;
        drive_start(4'd15, 4'd1);
        wait_done(10, cyc);
        n_checks++; if (cyc != 4 || done !== 1'b1) begin n_fail++; $display("FAIL val1_latency got %0d want 4", cyc); end
        n_checks++; if (quotient !== 4'd15) begin n_fail++; $display("FAIL val1_quotient got %0d want 15", quotient); end
        n_checks++; if (remainder !== 4'd0) begin n_fail++; $display("FAIL val1_remainder got %0d want 0", remainder); end
        @(negedge clock);
        drive_start(4'd3, 4'd9);
        wait_done(10, cyc);
        n_checks++; if (cyc != 4 || done !== 1'b1) begin n_fail++; $display("FAIL val2_latency got %0d want 4", cyc); end
        n_checks++; if (quotient !== 4'd0) begin n_fail++; $display("FAIL val2_quotient got %0d want 0", quotient); end
        n_checks++; if (remainder !== 4'd3) begin n_fail++; $display("FAIL val2_remainder got %0d want 3", remainder); end
        @(negedge clock);
    endtask

    task automatic test_div_zero();
        drive_start(4'd7, 4'd0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL dz_done got %b want 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dz_busy got %b want 0", busy); end
        n_checks++; if (quotient !== 4'd15) begin n_fail++; $display("FAIL dz_quotient got %0d want 15", quotient); end
        n_checks++; if (remainder !== 4'd7) begin n_fail++; $display("FAIL dz_remainder got %0d want 7", remainder); end
        n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
        @(negedge clock);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL dz_after got done=%b busy=%b want 0 0", done, busy); end
        n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag_hold got %b want 1", div_by_zero); end
    endtask

    task automatic test_ignore_start();
        int cyc;
        drive_start(4'd12, 4'd5);
        @(negedge clock);
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd3;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy got %b want 1", busy); end
        wait_done(10, cyc);
        n_checks++; if (cyc != 2 || done !== 1'b1) begin n_fail++; $display("FAIL ign_latency got %0d want 2", cyc); end
        n_checks++; if (quotient !== 4'd2) begin n_fail++; $display("FAIL ign_quotient got %0d want 2", quotient); end
        n_checks++; if (remainder !== 4'd2) begin n_fail++; $display("FAIL ign_remainder got %0d want 2", remainder); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL ign_dbz got %b want 0", div_by_zero); end
        @(negedge clock);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_queue got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_reset_abort();
        int cyc;
        bit seen_done = 1'b0;
        drive_start(4'd14, 4'd3);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
        n_checks++; if (quotient !== 4'd0 || remainder !== 4'd0) begin n_fail++; $display("FAIL abort_results got %0d/%0d want 0/0", quotient, remainder); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL abort_dbz got %b want 0", div_by_zero); end
        for (int j = 0; j < 8; j++) begin
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
            @(negedge clock);
        end
        n_checks++; if (seen_done) begin n_fail++; $display("FAIL abort_no_done got activity=1 want 0"); end
        drive_start(4'd14, 4'd3);
        wait_done(10, cyc);
        n_checks++; if (cyc != 4 || done !== 1'b1) begin n_fail++; $display("FAIL abort_retry_latency got %0d want 4", cyc); end
        n_checks++; if (quotient !== 4'd4 || remainder !== 4'd2) begin n_fail++; $display("FAIL abort_retry got %0d/%0d want 4/2", quotient, remainder); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] prev_q = 4'd4;
        logic [WIDTH-1:0] prev_r = 4'd2;
        logic [WIDTH-1:0] exp_q;
        logic [WIDTH-1:0] exp_r;
        int a, b, cyc, exp_cyc;
        start    = 1'b1;
        dividend = 4'd0;
        divisor  = 4'd0;
        for (int idx = 0; idx < 256; idx++) begin
            a = idx / 16;
            b = idx % 16;
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
            cyc = 0;
            while (done !== 1'b1 && cyc < 10) begin
                n_checks++;
                if (quotient !== prev_q || remainder !== prev_r) begin
                    n_fail++;
                    $display("FAIL sweep_stable %0d/%0d got %0d/%0d want %0d/%0d", a, b, quotient, remainder, prev_q, prev_r);
                end
                @(negedge clock);
                cyc++;
            end
            if (b == 0) begin
                exp_q   = 4'd15;
                exp_r   = 4'(a);
                exp_cyc = 0;
            end else begin
                exp_q   = 4'(a / b);
                exp_r   = 4'(a % b);
                exp_cyc = 4;
            end
            n_checks++;
            if (done !== 1'b1 || cyc != exp_cyc) begin
                n_fail++;
                $display("FAIL sweep_latency %0d/%0d got %0d want %0d", a, b, cyc, exp_cyc);
            end
            n_checks++;
            if (quotient !== exp_q || remainder !== exp_r || div_by_zero !== (b == 0)) begin
                n_fail++;
                $display("FAIL sweep_result %0d/%0d got %0d/%0d dbz=%b want %0d/%0d dbz=%b", a, b, quotient, remainder, div_by_zero, exp_q, exp_r, (b == 0));
            end
            if (b != 0) begin
                n_checks++;
                if (int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b) begin
                    n_fail++;
                    $display("FAIL sweep_invariant %0d/%0d got q=%0d r=%0d", a, b, quotient, remainder);
                end
            end
            prev_q = exp_q;
            prev_r = exp_r;
            if (idx < 255) begin
                start    = 1'b1;
                dividend = 4'((idx + 1) / 16);
                divisor  = 4'((idx + 1) % 16);
            end
        end
        @(negedge clock);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL sweep_final_done got %b want 0", done); end
        n_checks++; if (quotient !== 4'd1 || remainder !== 4'd0) begin n_fail++; $display("FAIL sweep_final_hold got %0d/%0d want 1/0", quotient, remainder); end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_values();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
